// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared run-control state encoding and default PC width for prog_ctr
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int PC_W_DEF = 10;

endpackage

// File: rtl/prog_ctr.sv
// rtl/prog_ctr.sv - program counter and IDLE/RUN/DONE run control for the 9-bit CPU
// Optional one-entry call/return link register enabled by defining PC_LINK_EN.
import pc_pkg::*;

module prog_ctr #(
    parameter int PC_W     = PC_W_DEF,
    parameter int PROG_LEN = 1023
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Halt,
    input  logic            Abs_jump,
    input  logic            Rel_jump,
    input  logic            Branch_cond,
    input  logic [7:0]      Target,
    input  logic            Link,
    input  logic            Ret,
    output logic [PC_W-1:0] PC,
    output logic            Running,
    output logic            Done
);

    localparam logic [PC_W-1:0] LAST = PROG_LEN[PC_W-1:0];

    pc_state_t       state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic            jump_taken;
    logic [PC_W-1:0] abs_target;
    logic [PC_W-1:0] rel_target;
    logic [PC_W-1:0] pc_inc;

    // Absolute targets are unsigned table entries; relative ones are signed offsets.
    assign abs_target = {{(PC_W-8){1'b0}}, Target};
    assign rel_target = pc + {{(PC_W-8){Target[7]}}, Target};
    assign pc_inc     = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign jump_taken = Abs_jump | (Rel_jump & Branch_cond);

`ifdef PC_LINK_EN
    logic [PC_W-1:0] link, link_n;
`else
    logic unused_link_inputs;
    assign unused_link_inputs = Link ^ Ret;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
`ifdef PC_LINK_EN
            link  <= '0;
`endif
        end else begin
            state <= state_n;
            pc    <= pc_n;
`ifdef PC_LINK_EN
            link  <= link_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
`ifdef PC_LINK_EN
        link_n  = link;
`endif
        case (state)
            IDLE: begin
                pc_n = '0;
                if (Start) state_n = RUN;
            end
            RUN: begin
                if (Halt) begin
                    state_n = DONE;
`ifdef PC_LINK_EN
                end else if (Ret) begin
                    pc_n = link;
`endif
                end else if ((pc == LAST) && !jump_taken) begin
                    state_n = DONE;
                end else if (Abs_jump) begin
                    pc_n = abs_target;
`ifdef PC_LINK_EN
                    if (Link) link_n = pc_inc;
`endif
                end else if (Rel_jump && Branch_cond) begin
                    pc_n = rel_target;
                end else begin
                    pc_n = pc_inc;
                end
            end
            DONE: begin
                if (Start) begin
                    state_n = RUN;
                    pc_n    = '0;
                end
            end
            default: begin
                state_n = IDLE;
                pc_n    = '0;
            end
        endcase
    end

    assign PC      = pc;
    assign Running = (state == RUN);
    assign Done    = (state == DONE);

endmodule

// File: tb/tb_prog_ctr.sv
// tb/tb_prog_ctr.sv - directed self-checking bench for prog_ctr
module tb_prog_ctr;

    localparam int PC_W = 10;

    logic            CLK = 1'b0;
    logic            Reset = 1'b1;
    logic            Start = 1'b0;
    logic            Halt = 1'b0;
    logic            Abs_jump = 1'b0;
    logic            Rel_jump = 1'b0;
    logic            Branch_cond = 1'b0;
    logic [7:0]      Target = 8'd0;
    logic            Link = 1'b0;
    logic            Ret = 1'b0;
    logic [PC_W-1:0] PC;
    logic            Running;
    logic            Done;

    int checks = 0;
    int errors = 0;

    prog_ctr #(.PC_W(PC_W), .PROG_LEN(1023)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt),
        .Abs_jump(Abs_jump), .Rel_jump(Rel_jump), .Branch_cond(Branch_cond),
        .Target(Target), .Link(Link), .Ret(Ret),
        .PC(PC), .Running(Running), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic s, input logic h, input logic a, input logic r,
                        input logic bc, input logic [7:0] t, input logic l, input logic rt);
        Start = s; Halt = h; Abs_jump = a; Rel_jump = r;
        Branch_cond = bc; Target = t; Link = l; Ret = rt;
        @(posedge CLK);
        #1;
        Start = 0; Halt = 0; Abs_jump = 0; Rel_jump = 0;
        Branch_cond = 0; Target = 0; Link = 0; Ret = 0;
    endtask

    task automatic chk3(input string tag, input int pc, input int run, input int dn);
        chk({tag, "_pc"}, int'(PC), pc);
        chk({tag, "_run"}, int'(Running), run);
        chk({tag, "_done"}, int'(Done), dn);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk3("reset", 0, 0, 0);
        Reset = 0;

        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("idle_hold", 0, 0, 0);

        step(1, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("start", 0, 1, 0);

        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 0, 8'd0, 0, 0);
            chk3($sformatf("seq%0d", i), i, 1, 0);
        end

        step(0, 0, 1, 0, 0, 8'd4, 0, 0);
        chk("abs_to4", int'(PC), 4);
        step(0, 0, 1, 0, 0, 8'd8, 0, 0);
        chk("abs_to8", int'(PC), 8);
        step(0, 0, 0, 1, 1, 8'hFD, 0, 0);
        chk("rel_back3", int'(PC), 5);
        step(0, 0, 1, 0, 0, 8'd8, 0, 0);
        step(0, 0, 0, 1, 0, 8'hFD, 0, 0);
        chk("rel_not_taken", int'(PC), 9);
        step(0, 0, 1, 1, 1, 8'd8, 0, 0);
        chk("abs_over_rel", int'(PC), 8);
        step(0, 0, 1, 0, 0, 8'hFD, 0, 0);
        chk("abs_zero_ext", int'(PC), 253);
        step(1, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("start_ignored", 254, 1, 0);

        step(0, 0, 1, 0, 0, 8'd1, 0, 0);
        step(0, 0, 0, 1, 1, 8'hFD, 0, 0);
        chk("rel_wrap", int'(PC), 1022);
        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        chk("to_last", int'(PC), 1023);
        step(0, 0, 1, 0, 0, 8'd36, 0, 0);
        chk3("jump_at_last", 36, 1, 0);
        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        chk("at37", int'(PC), 37);

        #2 Reset = 1;
        #1;
        chk3("async_reset", 0, 0, 0);
        #1 Reset = 0;
        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("after_reset_idle", 0, 0, 0);

        step(1, 0, 0, 0, 0, 8'd0, 0, 0);
        step(0, 0, 1, 0, 0, 8'd1, 0, 0);
        step(0, 0, 0, 1, 1, 8'hFD, 0, 0);
        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("last_again", 1023, 1, 0);
        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("end_of_prog", 1023, 0, 1);
        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("done_hold", 1023, 0, 1);
        step(1, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("restart", 0, 1, 0);

        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        step(0, 1, 1, 0, 0, 8'd8, 0, 0);
        chk3("halt_over_abs", 1, 0, 1);
        step(1, 0, 0, 0, 0, 8'd0, 0, 0);
        chk3("restart2", 0, 1, 0);

        step(0, 0, 1, 0, 0, 8'd20, 0, 0);
        step(0, 0, 1, 0, 0, 8'd100, 1, 0);
        chk("call", int'(PC), 100);
        step(0, 0, 0, 0, 0, 8'd0, 0, 0);
        step(0, 0, 0, 0, 0, 8'd0, 0, 1);
`ifdef PC_LINK_EN
        chk("ret", int'(PC), 21);
`else
        chk("ret_ignored", int'(PC), 102);
`endif
        step(0, 0, 1, 0, 0, 8'd30, 0, 0);
        step(0, 0, 0, 0, 0, 8'd0, 0, 1);
`ifdef PC_LINK_EN
        chk("ret_again", int'(PC), 21);
`else
        chk("ret_at30", int'(PC), 31);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
